// File: rtl/button_event_arbiter.sv
`timescale 1ns/1ps
// Debounced levels -> press/release/long/repeat events, round-robin onto one valid/ready slot.
// Input change to evt_valid is 2 cycles; the slot holds under evt_ready=0, and a full pend bit drops new events into sticky ovf.
module button_event_arbiter #(
  parameter int NUM_BTNS      = 4,
  parameter int ID_W          = 2,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_level,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  output logic [1:0]          evt_type,
  output logic                ovf,
  input  logic                ovf_clr
);
  localparam int              NE     = 2**ID_W;
  localparam logic [31:0]     LC     = 32'(LONG_CYCLES);
  localparam logic [31:0]     LC_M1  = 32'(LONG_CYCLES - 1);
  localparam logic [31:0]     RC_M1  = 32'(REPEAT_CYCLES - 1);
  localparam logic            REP_EN = (REPEAT_CYCLES > 0);
  localparam logic [ID_W:0]   NB     = (ID_W+1)'(NUM_BTNS);
  localparam logic [ID_W-1:0] LAST   = ID_W'(NUM_BTNS - 1);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } evt_e;

  logic [NUM_BTNS-1:0] r_prev;
  logic [NUM_BTNS-1:0] r_pend_press, r_pend_long, r_pend_rep, r_pend_rel;
  logic [31:0]         r_hold_cnt [NUM_BTNS];
  logic [31:0]         r_rep_cnt  [NUM_BTNS];
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_evt_valid;
  logic [ID_W-1:0]     r_evt_id;
  logic [1:0]          r_evt_type;
  logic                r_ovf;

  logic [NUM_BTNS-1:0] w_rise, w_fall, w_held, w_set_long, w_set_rep;
  logic [NUM_BTNS-1:0] w_clr_press, w_clr_long, w_clr_rep, w_clr_rel;
  logic [NE-1:0]       w_press_x, w_long_x, w_rep_x, w_rel_x, w_any_x;
  logic [NE-1:0]       w_clr_press_x, w_clr_long_x, w_clr_rep_x, w_clr_rel_x;
  logic                w_load, w_found, w_gnt_vld, w_ovf_evt;
  logic [ID_W:0]       w_sum;
  logic [ID_W-1:0]     w_gnt_idx;
  evt_e                w_gnt_type;

  assign w_rise = btn_level & ~r_prev;
  assign w_fall = ~btn_level & r_prev;
  assign w_held = btn_level & r_prev;
  assign w_load = !r_evt_valid || evt_ready;

  always_comb begin
    w_set_long = '0;
    w_set_rep  = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      w_set_long[i] = w_held[i] && (r_hold_cnt[i] == LC_M1);
      w_set_rep[i]  = REP_EN && w_held[i] && (r_hold_cnt[i] == LC) && (r_rep_cnt[i] == RC_M1);
    end
  end

  // Pend vectors padded to the full ID space so absent buttons read as idle.
  assign w_press_x = NE'(r_pend_press);
  assign w_long_x  = NE'(r_pend_long);
  assign w_rep_x   = NE'(r_pend_rep);
  assign w_rel_x   = NE'(r_pend_rel);
  assign w_any_x   = w_press_x | w_long_x | w_rep_x | w_rel_x;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int off = 0; off < NUM_BTNS; off++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
      if (w_sum >= NB) w_sum = w_sum - NB;
      if (!w_found && w_any_x[w_sum[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[ID_W-1:0];
      end
    end
    w_gnt_vld = w_found && w_load;
  end

  // Press before long before repeat before release keeps each button's events in order.
  always_comb begin
    w_gnt_type    = EV_RELEASE;
    w_clr_press_x = '0;
    w_clr_long_x  = '0;
    w_clr_rep_x   = '0;
    w_clr_rel_x   = '0;
    if (w_gnt_vld) begin
      if (w_press_x[w_gnt_idx]) begin
        w_gnt_type               = EV_PRESS;
        w_clr_press_x[w_gnt_idx] = 1'b1;
      end else if (w_long_x[w_gnt_idx]) begin
        w_gnt_type              = EV_LONG;
        w_clr_long_x[w_gnt_idx] = 1'b1;
      end else if (w_rep_x[w_gnt_idx]) begin
        w_gnt_type             = EV_REPEAT;
        w_clr_rep_x[w_gnt_idx] = 1'b1;
      end else begin
        w_gnt_type             = EV_RELEASE;
        w_clr_rel_x[w_gnt_idx] = 1'b1;
      end
    end
  end

  assign w_clr_press = w_clr_press_x[NUM_BTNS-1:0];
  assign w_clr_long  = w_clr_long_x[NUM_BTNS-1:0];
  assign w_clr_rep   = w_clr_rep_x[NUM_BTNS-1:0];
  assign w_clr_rel   = w_clr_rel_x[NUM_BTNS-1:0];

  assign w_ovf_evt = |((w_rise     & r_pend_press & ~w_clr_press) |
                       (w_set_long & r_pend_long  & ~w_clr_long)  |
                       (w_set_rep  & r_pend_rep   & ~w_clr_rep)   |
                       (w_fall     & r_pend_rel   & ~w_clr_rel));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev       <= '0;
      r_pend_press <= '0;
      r_pend_long  <= '0;
      r_pend_rep   <= '0;
      r_pend_rel   <= '0;
      r_rr_ptr     <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_evt_type   <= EV_PRESS;
      r_ovf        <= 1'b0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        r_hold_cnt[i] <= '0;
        r_rep_cnt[i]  <= '0;
      end
    end else begin
      r_prev       <= btn_level;
      r_pend_press <= (r_pend_press & ~w_clr_press) | w_rise;
      r_pend_long  <= (r_pend_long  & ~w_clr_long)  | w_set_long;
      r_pend_rep   <= (r_pend_rep   & ~w_clr_rep)   | w_set_rep;
      r_pend_rel   <= (r_pend_rel   & ~w_clr_rel)   | w_fall;

      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;

      if (w_load) r_evt_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_evt_id   <= w_gnt_idx;
        r_evt_type <= w_gnt_type;
        r_rr_ptr   <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
      end

      // Hold counter saturates at LC; only then does the repeat counter run.
      for (int i = 0; i < NUM_BTNS; i++) begin
        if (w_rise[i]) begin
          r_hold_cnt[i] <= '0;
        end else if (w_held[i]) begin
          if (r_hold_cnt[i] != LC) r_hold_cnt[i] <= r_hold_cnt[i] + 32'd1;
          if (w_set_long[i] || w_set_rep[i])
            r_rep_cnt[i] <= '0;
          else if (REP_EN && (r_hold_cnt[i] == LC))
            r_rep_cnt[i] <= r_rep_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_type  = r_evt_type;
  assign ovf       = r_ovf;

endmodule
